// File: rtl/key_event_scheduler_pkg.sv
// key_event_scheduler_pkg: event encodings, field widths and a shared priority helper
package key_event_scheduler_pkg;

    localparam int CODE_W = 8;
    localparam int TYPE_W = 2;
    localparam int IDX_W  = 5;
    localparam int SW_N   = 24;
    localparam int BTN_N  = 8;

    localparam logic [TYPE_W-1:0] EV_PRESS  = 2'b00;
    localparam logic [TYPE_W-1:0] EV_REPEAT = 2'b01;
    localparam logic [TYPE_W-1:0] EV_SW_ON  = 2'b10;
    localparam logic [TYPE_W-1:0] EV_SW_OFF = 2'b11;

    // index of the lowest set bit; zero when nothing is set
    function automatic logic [IDX_W-1:0] lowest_set(input logic [SW_N-1:0] v);
        lowest_set = '0;
        for (int i = SW_N - 1; i >= 0; i--)
            if (v[i]) lowest_set = IDX_W'(i);
    endfunction

endpackage

// File: rtl/key_event_scheduler_event_fifo.sv
// event_fifo: small circular queue of event codes with a registered occupancy count
module event_fifo
    import key_event_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     power,
    input  logic                     push,
    input  logic                     pop,
    input  logic [CODE_W-1:0]        din,
    output logic [CODE_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic do_push;
    logic do_pop;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rp];

    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    // pointers wrap naturally at the power-of-two depth; level tracks occupancy
    always_ff @(posedge clk) begin
        if (!power) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// key_event_scheduler: orders button presses, auto-repeats and switch changes into one handshaked event stream
module key_event_scheduler
    import key_event_scheduler_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic        clk,
    input  logic        power,
    input  logic [23:0] switch,
    input  logic [15:0] button,
    output logic        ev_valid,
    output logic [7:0]  ev_code,
    input  logic        ev_ready,
    output logic        ev_lost,
    output logic [2:0]  fifo_level
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_t;

    rpt_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [BTN_N-1:0] held;
    logic [BTN_N-1:0] held_prev;
    logic [BTN_N-1:0] press_pend;
    logic [SW_N-1:0] sw_prev;
    logic [SW_N-1:0] sw_pend;
    logic rpt_pend;
    logic [IDX_W-1:0] rpt_idx;
    logic [IDX_W-1:0] target;
    logic [IDX_W-1:0] press_idx;
    logic [IDX_W-1:0] sw_idx;
    logic tick;
    logic full;
    logic empty;
    logic grant;
    logic [BTN_N-1:0] g_press;
    logic [SW_N-1:0] g_sw;
    logic g_rpt;
    logic [CODE_W-1:0] code;
    logic [$clog2(DEPTH):0] level;

    assign held      = button[15:8];
    assign target    = lowest_set(SW_N'(held));
    assign press_idx = lowest_set(SW_N'(press_pend));
    assign sw_idx    = lowest_set(sw_pend);
    assign tick      = held == held_prev &&
                       ((state == DELAY  && cnt == CNT_W'(REPEAT_DELAY - 1)) ||
                        (state == REPEAT && cnt == CNT_W'(REPEAT_PERIOD - 1)));

    // hold-to-repeat FSM: any change of the held set restarts the initial delay
    always_ff @(posedge clk) begin
        if (!power) begin
            state     <= IDLE;
            cnt       <= '0;
            held_prev <= '0;
        end else begin
            held_prev <= held;
            if (held != held_prev) begin
                state <= (|held) ? DELAY : IDLE;
                cnt   <= '0;
            end else if (tick) begin
                state <= REPEAT;
                cnt   <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // fixed-priority grant of one pending source per cycle while the queue has room
    always_comb begin
        g_press = '0;
        g_sw    = '0;
        g_rpt   = 1'b0;
        code    = '0;
        if (!full) begin
            if (|press_pend) begin
                g_press[press_idx[2:0]] = 1'b1;
                code = {EV_PRESS, 1'b0, press_idx};
            end else if (rpt_pend) begin
                g_rpt = 1'b1;
                code  = {EV_REPEAT, 1'b0, rpt_idx};
            end else if (|sw_pend) begin
                g_sw[sw_idx] = 1'b1;
                code = {switch[sw_idx] ? EV_SW_ON : EV_SW_OFF, 1'b0, sw_idx};
            end
        end
    end

    assign grant = (|g_press) || (|g_sw) || g_rpt;

    // pending capture: a new set beats a same-cycle grant; a set on an ungranted pending bit is lost
    always_ff @(posedge clk) begin
        if (!power) begin
            press_pend <= '0;
            sw_pend    <= '0;
            rpt_pend   <= 1'b0;
            rpt_idx    <= '0;
            sw_prev    <= switch;
            ev_lost    <= 1'b0;
        end else begin
            press_pend <= (press_pend & ~g_press) | button[7:0];
            sw_pend    <= (sw_pend & ~g_sw) | (switch ^ sw_prev);
            rpt_pend   <= (rpt_pend & ~g_rpt) | tick;
            sw_prev    <= switch;
            if (tick) rpt_idx <= target;
            if ((|(button[7:0] & press_pend & ~g_press)) ||
                (|((switch ^ sw_prev) & sw_pend & ~g_sw)) ||
                (tick && rpt_pend && !g_rpt))
                ev_lost <= 1'b1;
        end
    end

    event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .power (power),
        .push  (grant),
        .pop   (ev_ready),
        .din   (code),
        .dout  (ev_code),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign ev_valid   = !empty;
    assign fifo_level = 3'(level);

endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Sits directly after input_process.
- Converts its debounced switch/button outputs into a single ordered stream of 8-bit input events, delivered to the mode/menu logic over a valid/ready handshake.
- Arbitrates simultaneous sources under fixed priority: button press, then auto-repeat, then switch change.
- Generates hold-to-repeat events and buffers events in a small FIFO, so no press is lost while the consumer is busy.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- REPEAT_DELAY, 50_000_000, cycles a button must be held before the first repeat event.
- REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat events.
- CNT_W, 26, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  in  1  system clock
- power  in  1  synchronous active-low reset (0 = reset)
- switch  in  24  debounced switch levels from input_process
- button  in  16  from input_process; [7:0] one-cycle press pulses, [15:8] debounced held levels
- ev_valid  out  1  FIFO head holds an event
- ev_code  out  8  head event: [7:6] type (00 press, 01 repeat, 10 switch-on, 11 switch-off), [5] 0, [4:0] source index
- ev_ready  in  1  consumer accepts head when ev_valid&ev_ready
- ev_lost  out  1  sticky; a source event arrived while its pending bit was already set
- fifo_level  out  3  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (power=0 at clk edge):
  - FIFO empty, all pending bits 0, repeat counter/state cleared.
  - sw_prev <= switch; no switch events are generated at power-up.
  - ev_valid=0, ev_code=0, ev_lost=0, fifo_level=0.
  - Reset mid-stream discards all queued and pending events.
- Pending capture, every cycle:
  - press_pend[i] sets on button[i].
  - sw_pend[j] sets when switch[j]!=sw_prev[j]; sw_prev <= switch.
  - rpt_pend sets on a repeat tick.
  - If a set condition coincides with the grant of the same bit, set wins and the bit stays pending.
  - A set on an already-pending bit that is not being granted sets ev_lost.
- Auto-repeat FSM, states IDLE, DELAY, REPEAT:
  - Target = lowest-index set bit of button[15:8]. Any change of button[15:8] returns to DELAY with counter=0, or to IDLE if no bit is held.
  - DELAY: counter counts up; at REPEAT_DELAY-1, issue tick, go to REPEAT, counter=0.
  - REPEAT: tick every REPEAT_PERIOD cycles.
  - Tick index = target.
- Arbiter, one grant per cycle, only when FIFO not full (registered full; no pass-through on simultaneous pop):
  - Priority order: lowest-index press_pend, then rpt_pend, then lowest-index sw_pend.
  - Switch event type comes from the switch level at grant cycle: 1→10, 0→11.
  - Granted bit is cleared at the edge that writes the FIFO.
- Latency: pulse at cycle N → pending at N+1 → written at N+1 edge → ev_valid in cycle N+2, when the FIFO is empty and no higher-priority bits are pending.
- FIFO:
  - Push and pop in the same cycle are allowed when not full; level is then unchanged.
  - Pop on empty is ignored.
  - ev_code holds the head value while ev_valid=1 and ev_ready=0.
  - ev_code=0 when empty.
  - Pointers wrap modulo DEPTH.
- fifo_level is registered, equal to occupancy.

Decomposition:
- Shared package: event type constants EV_PRESS=2'b00, EV_REPEAT=2'b01, EV_SW_ON=2'b10, EV_SW_OFF=2'b11; event field widths.
- Sub-module: event_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/level).
- Arbiter and repeat FSM stay in the top.

Test Plan:
- Reset with switch=24'h100000 held, release power, hold 20 cycles → no events, ev_valid=0, fifo_level=0.
- button[0] and button[3] pulse in the same cycle, ev_ready=1 → ev_code 8'h00 then 8'h03 on consecutive cycles; first ev_valid 2 cycles after the pulse.
- REPEAT_DELAY=10, REPEAT_PERIOD=4; hold button[10] for 30 cycles → press event 8'h02 (from the pulse on bit 2), then 01_00010 repeat events at hold+10, +14, +18, …; releasing stops repeats.
- ev_ready=0; pulse buttons 0–5 one per cycle → fifo_level saturates at 4; bits 4 and 5 remain pending; after ev_ready=1, order is 00,01,02,03,04,05 and ev_lost=0.
- ev_ready=0 with FIFO full; pulse button[6] twice → ev_lost=1, exactly one 8'h06 event eventually.
- switch 24'h0→24'h100000, then back to 24'h0 ten cycles later with ev_ready=1 → events 8'h94 then 8'hD4.
